// File: rtl/srf_port_arbiter.sv
// srf_port_arbiter: round-robin sharing of the SRF read port (dual-source) and write port among NUM_REQ requesters
// Optional feature macro: SRF_ARB_RAW_STALL_EN (stall reads that collide with a same-cycle granted write)
module srf_port_arbiter #(
  parameter int NUM_STREAM_ID = 5,
  parameter int NUM_REQ = 4,
  parameter int REQ_ID_W = $clog2(NUM_REQ)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     rd_req_valid,
  input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0]  rd_req_src1,
  input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0]  rd_req_src2,
  output logic [NUM_REQ-1:0]                     rd_req_ready,
  input  logic [NUM_REQ-1:0]                     wr_req_valid,
  input  logic [NUM_REQ-1:0][NUM_STREAM_ID-1:0]  wr_req_dest,
  output logic [NUM_REQ-1:0]                     wr_req_ready,
  output logic                                   srf_read_enable,
  output logic [NUM_STREAM_ID-1:0]               stream_src1,
  output logic [NUM_STREAM_ID-1:0]               stream_src2,
  output logic                                   srf_write_enable,
  output logic [NUM_STREAM_ID-1:0]               stream_dest,
  output logic [REQ_ID_W-1:0]                    wr_sel,
  output logic                                   rd_rsp_valid,
  output logic [REQ_ID_W-1:0]                    rd_rsp_id
);
  logic [REQ_ID_W-1:0] rd_ptr, wr_ptr, rd_idx, wr_idx, rj, wj;
  logic                rd_found, wr_found, rsp_v;
  logic [NUM_REQ-1:0]  rd_elig;

  // write winner: first valid requester at or above wr_ptr, wrapping; nothing wins during reset
  always_comb begin
    wr_found = 1'b0;
    wr_idx = '0;
    wj = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      wj = REQ_ID_W'((int'(wr_ptr) + o) % NUM_REQ);
      if (!rst && !wr_found && wr_req_valid[wj]) begin
        wr_found = 1'b1;
        wr_idx = wj;
      end
    end
  end

  assign wr_req_ready     = wr_found ? (NUM_REQ'(1) << wr_idx) : '0;
  assign srf_write_enable = wr_found;
  assign stream_dest      = wr_found ? wr_req_dest[wr_idx] : '0;
  assign wr_sel           = wr_idx;

  // read eligibility: optionally drop readers whose sources hit the stream being written this cycle
  always_comb begin
    rd_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SRF_ARB_RAW_STALL_EN
      rd_elig[i] = rd_req_valid[i] && !(wr_found && (rd_req_src1[i] == stream_dest || rd_req_src2[i] == stream_dest));
`else
      rd_elig[i] = rd_req_valid[i];
`endif
    end
  end

  // read winner: first eligible requester at or above rd_ptr, wrapping; nothing wins during reset
  always_comb begin
    rd_found = 1'b0;
    rd_idx = '0;
    rj = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      rj = REQ_ID_W'((int'(rd_ptr) + o) % NUM_REQ);
      if (!rst && !rd_found && rd_elig[rj]) begin
        rd_found = 1'b1;
        rd_idx = rj;
      end
    end
  end

  assign rd_req_ready    = rd_found ? (NUM_REQ'(1) << rd_idx) : '0;
  assign srf_read_enable = rd_found;
  assign stream_src1     = rd_found ? rd_req_src1[rd_idx] : '0;
  assign stream_src2     = rd_found ? rd_req_src2[rd_idx] : '0;

  // a reset arriving while read data is on the bus cancels that response
  assign rd_rsp_valid = rsp_v && !rst;

  // pointers advance past each winner; the response tracks the read issued last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      rsp_v <= 1'b0;
      rd_rsp_id <= '0;
    end else begin
      if (wr_found) wr_ptr <= (wr_idx == REQ_ID_W'(NUM_REQ - 1)) ? '0 : wr_idx + 1'b1;
      if (rd_found) rd_ptr <= (rd_idx == REQ_ID_W'(NUM_REQ - 1)) ? '0 : rd_idx + 1'b1;
      rsp_v <= rd_found;
      rd_rsp_id <= rd_idx;
    end
  end
endmodule
